mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported main data memory (32-bit data, 22-bit word address, reads/writes complete on clock low).
- Shares the memory between the instruction-fetch port (read-only) and the data port (read/write).
- Guarantees the memory never sees re and we together, and returns registered read data with a one-cycle ack pulse.

Parameters:
- ADDR_W, 22, word-address width on all ports.
- DATA_W, 32, data width.
- MEM_DEPTH, 65536, number of implemented words; addresses >= MEM_DEPTH are rejected.

Ports:
- clk  in  1  system clock; memory acts on clk low.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  ADDR_W  fetch word address.
- i_ack  out  1  one-cycle completion pulse for the fetch port.
- i_rd_data  out  DATA_W  fetched word; valid while i_ack is high, held afterwards.
- i_err  out  1  high with i_ack when i_addr was out of range.
- d_req  in  1  data request; held with d_wr, d_addr and d_wrt_data until d_ack.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wrt_data  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rd_data  out  DATA_W  read word; valid while d_ack is high, held afterwards.
- d_err  out  1  high with d_ack when d_addr was out of range.
- mem_addr  out  ADDR_W  registered memory address.
- mem_re  out  1  registered memory read enable.
- mem_we  out  1  registered memory write enable.
- mem_wrt_data  out  DATA_W  registered memory write data.
- mem_rd_data  in  DATA_W  memory read data, stable by the rising edge that ends the access cycle.
- busy  out  1  high in ACCESS and ACK states.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=D, and all outputs are 0 (including read-data registers, mem_* and busy). Reset mid-access abandons the access; no ack is issued.
- States:
  - IDLE: if no request, stay in IDLE. If any request, arbitrate, register mem_* and go to ACCESS.
  - ACCESS: exactly one cycle. mem_re or mem_we is high for the granted, in-range request. On the closing edge, capture mem_rd_data for a read, drop mem_re/mem_we, then go to ACK.
  - ACK: the granted port's ack is high for exactly one cycle; always returns to IDLE.
- Latency: request present at the rising edge ending IDLE -> ACCESS next cycle -> ack the following cycle. That is 2 cycles from sampling to ack, and 3 cycles minimum per transaction.
- Requests are sampled only in IDLE.
- A requester that wants no further access must drop req in the cycle after its ack.
- A req still high in the IDLE after its ack is treated as a new request, by design.
- Write: mem_we=1, mem_re=0, mem_wrt_data=d_wrt_data during ACCESS. d_rd_data is unchanged; d_ack pulses in ACK.
- Read: mem_re=1, mem_we=0. The granted port's rd_data is loaded from mem_rd_data at the end of ACCESS.
- mem_re and mem_we are never high together under any input.
- mem_addr and mem_wrt_data hold their last values when idle.
- Out-of-range request (addr >= MEM_DEPTH):
  - The FSM still passes through ACCESS, but mem_re=mem_we=0.
  - In ACK: ack=1, err=1, and the port's rd_data is forced to 0.
  - err is 0 whenever ack is 0.
- Simultaneous i_req and d_req: the arbitration policy in Optional Feature decides. last_grant is updated on every grant.
- A port's req dropping during ACCESS or ACK does not cancel the transaction; the ack is still issued.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie, grant the port that is not last_grant. Strict alternation, so neither port starves.
- Undefined: fixed priority, data port always wins a tie. last_grant is still tracked but unused.

Test Plan:
- Reset then i_req=1, i_addr=0x00010, memory word 0x10 = 0xDEADBEEF -> mem_re=1 with mem_addr=0x10 in ACCESS. Next cycle i_ack=1, i_rd_data=0xDEADBEEF, i_err=0.
- d_req=1, d_wr=1, d_addr=0x0FFFF, d_wrt_data=0x12345678, then a d read of 0x0FFFF -> mem_we=1 only in the first ACCESS, the first d_ack has d_err=0, and the read returns 0x12345678.
- d_addr=0x10000 read, then write -> no mem_re/mem_we ever asserted, and d_ack=1 with d_err=1 and d_rd_data=0 each time.
- i_req and d_req both held high for 4 transactions -> with ARB_ROUND_ROBIN_EN, grants go I,D,I,D. Without it, grants go D,D,D,D while d_req stays high. Check that re and we are never high together.
- Assert rst_n=0 asynchronously mid-ACCESS -> all outputs 0 immediately. After release with no req, no ack is seen, and the first tie goes to I (round-robin build).
- Back-to-back: i_req held high through the ack -> a second fetch starts, and i_ack pulses exactly every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported data memory: IDLE -> ACCESS -> ACK.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W    = 22,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 65536
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rd_data,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wrt_data,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rd_data,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wrt_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;    // 1 = data port held the last grant
   logic              grant_d_q, grant_d_d;  // 1 = current transaction belongs to the data port
   logic              err_q, err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wrt_data_q, mem_wrt_data_d;
   logic [DATA_W-1:0] i_rd_data_q, i_rd_data_d;
   logic [DATA_W-1:0] d_rd_data_q, d_rd_data_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              i_err_q, i_err_d;
   logic              d_err_q, d_err_d;
   logic              pick_d;
   logic              i_in_range, d_in_range;

   assign i_in_range = 32'(i_addr) < MEM_DEPTH;
   assign d_in_range = 32'(d_addr) < MEM_DEPTH;

   always_comb begin
      pick_d = d_req;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick_d = ~last_d_q;
`else
         pick_d = 1'b1;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      last_d_d       = last_d_q;
      grant_d_d      = grant_d_q;
      err_d          = err_q;
      mem_addr_d     = mem_addr_q;
      mem_re_d       = 1'b0;
      mem_we_d       = 1'b0;
      mem_wrt_data_d = mem_wrt_data_q;
      i_rd_data_d    = i_rd_data_q;
      d_rd_data_d    = d_rd_data_q;
      i_ack_d        = 1'b0;
      d_ack_d        = 1'b0;
      i_err_d        = 1'b0;
      d_err_d        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_req || d_req) begin
               grant_d_d = pick_d;
               last_d_d  = pick_d;
               state_d   = StAccess;
               if (pick_d) begin
                  mem_addr_d = d_addr;
                  err_d      = ~d_in_range;
                  mem_re_d   = d_in_range & ~d_wr;
                  mem_we_d   = d_in_range & d_wr;
                  if (d_wr) mem_wrt_data_d = d_wrt_data;
               end else begin
                  mem_addr_d = i_addr;
                  err_d      = ~i_in_range;
                  mem_re_d   = i_in_range;
               end
            end
         end
         StAccess: begin
            state_d = StAck;
            if (grant_d_q) begin
               d_ack_d = 1'b1;
               d_err_d = err_q;
               if (err_q) d_rd_data_d = '0;
               else if (mem_re_q) d_rd_data_d = mem_rd_data;
            end else begin
               i_ack_d = 1'b1;
               i_err_d = err_q;
               if (err_q) i_rd_data_d = '0;
               else if (mem_re_q) i_rd_data_d = mem_rd_data;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         last_d_q       <= 1'b1;
         grant_d_q      <= 1'b0;
         err_q          <= 1'b0;
         mem_addr_q     <= '0;
         mem_re_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_wrt_data_q <= '0;
         i_rd_data_q    <= '0;
         d_rd_data_q    <= '0;
         i_ack_q        <= 1'b0;
         d_ack_q        <= 1'b0;
         i_err_q        <= 1'b0;
         d_err_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_d_q       <= last_d_d;
         grant_d_q      <= grant_d_d;
         err_q          <= err_d;
         mem_addr_q     <= mem_addr_d;
         mem_re_q       <= mem_re_d;
         mem_we_q       <= mem_we_d;
         mem_wrt_data_q <= mem_wrt_data_d;
         i_rd_data_q    <= i_rd_data_d;
         d_rd_data_q    <= d_rd_data_d;
         i_ack_q        <= i_ack_d;
         d_ack_q        <= d_ack_d;
         i_err_q        <= i_err_d;
         d_err_q        <= d_err_d;
      end
   end

   assign i_ack        = i_ack_q;
   assign i_err        = i_err_q;
   assign i_rd_data    = i_rd_data_q;
   assign d_ack        = d_ack_q;
   assign d_err        = d_err_q;
   assign d_rd_data    = d_rd_data_q;
   assign mem_addr     = mem_addr_q;
   assign mem_re       = mem_re_q;
   assign mem_we       = mem_we_q;
   assign mem_wrt_data = mem_wrt_data_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory environment, shadow-memory reference model,
// directed scenarios plus randomized mixed traffic.
module tb_mem_port_arbiter;

   localparam int unsigned DEPTH = 65536;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [21:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rd_data;
   logic        i_err;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [21:0] d_addr = '0;
   logic [31:0] d_wrt_data = '0;
   logic        d_ack;
   logic [31:0] d_rd_data;
   logic        d_err;
   logic [21:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_wrt_data;
   logic [31:0] mem_rd_data = '0;
   logic        busy;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rd_data(i_rd_data), .i_err(i_err),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wrt_data(d_wrt_data),
      .d_ack(d_ack), .d_rd_data(d_rd_data), .d_err(d_err),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wrt_data(mem_wrt_data),
      .mem_rd_data(mem_rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Environment memory acts on clock low; ref_mem is the model's independent shadow.
   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];

   always @(negedge clk) begin
      if (mem_we) mem[mem_addr[15:0]] <= mem_wrt_data;
      if (mem_re) mem_rd_data <= mem[mem_addr[15:0]];
   end

   bit both_seen, re_seen, we_seen, ack_seen;
   always @(negedge clk) begin
      if (mem_re && mem_we) both_seen = 1'b1;
      if (mem_re) re_seen = 1'b1;
      if (mem_we) we_seen = 1'b1;
      if (i_ack || d_ack) ack_seen = 1'b1;
   end

   int unsigned total = 0;
   int unsigned passed = 0;
   bit          model_last_d = 1'b1;
   logic [31:0] exp_i_rd = '0;
   logic [31:0] exp_d_rd = '0;

   function automatic bit pred_d(input bit ir, input bit dr);
      if (ir && dr) return RR ? !model_last_d : 1'b1;
      return dr;
   endfunction

   function automatic logic [21:0] pick_addr();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return 22'(32'h10000 + $urandom_range(0, 3));
      if (sel == 1) return 22'h3FFFFF;
      return 22'(32'hFFF8 + $urandom_range(0, 7));
   endfunction

   task automatic clear_flags();
      re_seen = 1'b0; we_seen = 1'b0; ack_seen = 1'b0;
   endtask

   task automatic wait_ack(output bit gi, output bit gd, output int cyc);
      gi = 1'b0; gd = 1'b0; cyc = 0;
      while (!(gi || gd) && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
         gi = i_ack;
         gd = d_ack;
      end
   endtask

   task automatic drain();
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_req = 1'b0; d_req = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      model_last_d = 1'b1;
      exp_i_rd = '0;
      exp_d_rd = '0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({i_ack, i_err, d_ack, d_err, mem_re, mem_we, busy} !== 7'b0)
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {i_ack, i_err, d_ack, d_err, mem_re, mem_we, busy});
      else passed++;
      total++;
      if ({i_rd_data, d_rd_data, mem_wrt_data, mem_addr} !== '0)
         $display("FAIL reset_data: got %h %h %h %h expected all 0",
                  i_rd_data, d_rd_data, mem_wrt_data, mem_addr);
      else passed++;
   endtask

   task automatic test_fetch();
      mem[16'h10] = 32'hDEADBEEF; ref_mem[16'h10] = 32'hDEADBEEF;
      i_addr = 22'h10; i_req = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({mem_re, mem_we, busy} !== 3'b101 || mem_addr !== 22'h10)
         $display("FAIL fetch_access: got re/we/busy=%b addr=%h expected 101 addr=000010",
                  {mem_re, mem_we, busy}, mem_addr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({i_ack, i_err, d_ack} !== 3'b100 || i_rd_data !== 32'hDEADBEEF)
         $display("FAIL fetch_ack: got ack/err/dack=%b data=%h expected 100 data=deadbeef",
                  {i_ack, i_err, d_ack}, i_rd_data);
      else passed++;
      i_req = 1'b0;
      @(posedge clk); #1;
      total++;
      if (i_ack !== 1'b0 || i_rd_data !== 32'hDEADBEEF)
         $display("FAIL fetch_hold: got ack=%b data=%h expected 0 deadbeef", i_ack, i_rd_data);
      else passed++;
      exp_i_rd = 32'hDEADBEEF;
      model_last_d = 1'b0;
      drain();
   endtask

   task automatic test_write_read();
      bit gi, gd;
      int cyc;
      clear_flags();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 22'h0FFFF; d_wrt_data = 32'h12345678;
      wait_ack(gi, gd, cyc);
      ref_mem[16'hFFFF] = 32'h12345678;
      total++;
      if (!gd || d_err !== 1'b0 || d_rd_data !== exp_d_rd || !we_seen || re_seen || cyc != 2)
         $display("FAIL write: got ack=%b err=%b rd=%h we=%b re=%b cyc=%0d expected 1 0 %h 1 0 2",
                  gd, d_err, d_rd_data, we_seen, re_seen, cyc, exp_d_rd);
      else passed++;
      d_req = 1'b0;
      @(posedge clk); #1;
      clear_flags();
      d_req = 1'b1; d_wr = 1'b0;
      wait_ack(gi, gd, cyc);
      exp_d_rd = ref_mem[16'hFFFF];
      total++;
      if (!gd || d_err !== 1'b0 || d_rd_data !== exp_d_rd || we_seen || !re_seen)
         $display("FAIL readback: got ack=%b err=%b rd=%h we=%b re=%b expected 1 0 %h 0 1",
                  gd, d_err, d_rd_data, we_seen, re_seen, exp_d_rd);
      else passed++;
      drain();
   endtask

   task automatic test_out_of_range();
      bit gi, gd;
      int cyc;
      for (int k = 0; k < 2; k++) begin
         clear_flags();
         d_req = 1'b1; d_wr = (k == 1); d_addr = 22'h10000; d_wrt_data = 32'hCAFEF00D;
         wait_ack(gi, gd, cyc);
         total++;
         if (!gd || d_err !== 1'b1 || d_rd_data !== 32'h0 || re_seen || we_seen)
            $display("FAIL oor_%0d: got ack=%b err=%b rd=%h re=%b we=%b expected 1 1 0 0 0",
                     k, gd, d_err, d_rd_data, re_seen, we_seen);
         else passed++;
         d_req = 1'b0;
         @(posedge clk); #1;
         total++;
         if (d_err !== 1'b0 || d_ack !== 1'b0)
            $display("FAIL oor_err_clear_%0d: got ack=%b err=%b expected 0 0", k, d_ack, d_err);
         else passed++;
      end
      exp_d_rd = '0;
      drain();
   endtask

   task automatic test_tie();
      bit gi, gd, win;
      int cyc;
      logic [31:0] exp;
      do_reset();
      both_seen = 1'b0;
      i_addr = 22'hFFF9; d_addr = 22'hFFFA; d_wr = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(gi, gd, cyc);
         win = pred_d(1'b1, 1'b1);
         model_last_d = win;
         exp = win ? ref_mem[16'hFFFA] : ref_mem[16'hFFF9];
         total++;
         if ({gi, gd} !== {!win, win} || (win ? d_rd_data : i_rd_data) !== exp)
            $display("FAIL tie_%0d: got i/d ack=%b%b data=%h expected %b%b data=%h",
                     k, gi, gd, win ? d_rd_data : i_rd_data, !win, win, exp);
         else passed++;
      end
      drain();
      total++;
      if (both_seen) $display("FAIL tie_re_we: got re&we together=1 expected 0");
      else passed++;
   endtask

   task automatic test_async_reset();
      bit gi, gd, win;
      int cyc;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 22'hFFF8;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({i_ack, i_err, d_ack, d_err, mem_re, mem_we, busy} !== 7'b0 ||
          {i_rd_data, d_rd_data, mem_wrt_data, mem_addr} !== '0)
         $display("FAIL async_reset: got ctrl=%b data=%h %h %h %h expected all 0",
                  {i_ack, i_err, d_ack, d_err, mem_re, mem_we, busy},
                  i_rd_data, d_rd_data, mem_wrt_data, mem_addr);
      else passed++;
      d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_last_d = 1'b1; exp_i_rd = '0; exp_d_rd = '0;
      clear_flags();
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (ack_seen) $display("FAIL reset_no_ack: got ack after reset=1 expected 0");
      else passed++;
      i_addr = 22'hFFFB; d_addr = 22'hFFFC;
      i_req = 1'b1; d_req = 1'b1;
      wait_ack(gi, gd, cyc);
      win = pred_d(1'b1, 1'b1);
      model_last_d = win;
      total++;
      if ({gi, gd} !== {!win, win})
         $display("FAIL first_tie: got i/d ack=%b%b expected %b%b", gi, gd, !win, win);
      else passed++;
      drain();
   endtask

   task automatic test_back_to_back();
      int acks[$];
      int cyc;
      cyc = 0;
      i_addr = 22'hFFFD; i_req = 1'b1;
      repeat (14) begin
         @(posedge clk); #1;
         cyc++;
         if (i_ack) begin
            acks.push_back(cyc);
            total++;
            if (i_rd_data !== ref_mem[16'hFFFD] || i_err !== 1'b0)
               $display("FAIL b2b_data: got %h err=%b expected %h err=0",
                        i_rd_data, i_err, ref_mem[16'hFFFD]);
            else passed++;
         end
      end
      exp_i_rd = ref_mem[16'hFFFD];
      model_last_d = 1'b0;
      total++;
      if (acks.size() != 5) $display("FAIL b2b_count: got %0d acks expected 5", acks.size());
      else passed++;
      for (int k = 1; k < acks.size(); k++) begin
         total++;
         if (acks[k] - acks[k-1] != 3)
            $display("FAIL b2b_spacing_%0d: got %0d cycles expected 3", k, acks[k] - acks[k-1]);
         else passed++;
      end
      drain();
   endtask

   task automatic test_random();
      bit ir, dr, wr, win, inr, gi, gd;
      int cyc;
      logic [21:0] ia, da;
      logic [31:0] wd;
      do_reset();
      both_seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         if (!ir && !dr) dr = 1'b1;
         ia = pick_addr(); da = pick_addr();
         wr = 1'($urandom_range(0, 1));
         wd = $urandom;
         i_addr = ia; d_addr = da; d_wr = wr; d_wrt_data = wd;
         i_req = ir; d_req = dr;
         wait_ack(gi, gd, cyc);
         win = pred_d(ir, dr);
         model_last_d = win;
         total++;
         if ({gi, gd} !== {!win, win} || cyc != 2)
            $display("FAIL rnd_grant_%0d: got i/d ack=%b%b cyc=%0d expected %b%b cyc=2",
                     n, gi, gd, cyc, !win, win);
         else passed++;
         if (win) begin
            inr = 32'(da) < DEPTH;
            if (!wr || !inr) exp_d_rd = inr ? ref_mem[da[15:0]] : 32'h0;
            if (wr && inr) ref_mem[da[15:0]] = wd;
            total++;
            if (d_err !== !inr || d_rd_data !== exp_d_rd)
               $display("FAIL rnd_d_%0d: got err=%b rd=%h expected err=%b rd=%h",
                        n, d_err, d_rd_data, !inr, exp_d_rd);
            else passed++;
         end else begin
            inr = 32'(ia) < DEPTH;
            exp_i_rd = inr ? ref_mem[ia[15:0]] : 32'h0;
            total++;
            if (i_err !== !inr || i_rd_data !== exp_i_rd)
               $display("FAIL rnd_i_%0d: got err=%b rd=%h expected err=%b rd=%h",
                        n, i_err, i_rd_data, !inr, exp_i_rd);
            else passed++;
         end
         i_req = 1'b0; d_req = 1'b0;
         @(posedge clk); #1;
      end
      total++;
      if (both_seen) $display("FAIL rnd_re_we: got re&we together=1 expected 0");
      else passed++;
   endtask

   initial begin
      for (int a = 0; a < int'(DEPTH); a++) begin
         mem[a] = $urandom;
         ref_mem[a] = mem[a];
      end
      test_reset();
      test_fetch();
      test_write_read();
      test_out_of_range();
      test_tie();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
